// File: rtl/spart_rx.sv
// SPART receive stage: 16x-oversampled 8N1 deserializer feeding a bus-side receive buffer.
// Define SPART_RX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
`timescale 1ns/1ps
module spart_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       baud_en,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       frame_err,
  output logic       overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [SYNC_STAGES-1:0] sync, sync_fill;
  logic                   rxs, line_ok;
  state_t                 state, state_n;
  logic [CW-1:0]          tick_cnt, tick_n;
  logic [2:0]             bit_idx, bit_n;
  logic [7:0]             shift, shift_n;
  logic                   armed, armed_n;
  logic                   push, stop_bad, drop;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '1;
      sync_fill <= '0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], rxd};
      sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // rxs holds reset ones until real line samples reach the last stage; do not arm on those.
  assign rxs     = sync[SYNC_STAGES-1];
  assign line_ok = sync_fill[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      armed    <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      armed    <= armed_n;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    bit_n    = bit_idx;
    shift_n  = shift;
    armed_n  = armed;
    push     = 1'b0;
    stop_bad = 1'b0;
    if (baud_en) begin
      unique case (state)
        IDLE: begin
          if (line_ok && rxs) begin
            armed_n = 1'b1;
          end else if (line_ok && armed) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_n = '0;
            if (rxs) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              bit_n   = '0;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == BIT_LAST) begin
            shift_n = {rxs, shift[7:1]};
            tick_n  = '0;
            bit_n   = bit_idx + 1'b1;
            if (bit_idx == 3'd7) state_n = STOP;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == BIT_LAST) begin
            push     = 1'b1;
            stop_bad = ~rxs;
            state_n  = IDLE;
            armed_n  = 1'b0;
            tick_n   = '0;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef SPART_RX_FIFO_EN
  logic [7:0] mem [4];
  logic [2:0] wr_ptr, rd_ptr;
  logic       empty, full, pop, wr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[2] != rd_ptr[2]) && (wr_ptr[1:0] == rd_ptr[1:0]);
  assign pop     = rd && !empty;
  assign wr      = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign rda     = !empty;
  assign rx_data = mem[rd_ptr[1:0]];

  // NOTE: storage is reset here because rx_data reads the head slot directly and must show 8'h00 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr[1:0]] <= shift;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
`else
  assign drop = push && rda && !rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data <= '0;
      rda     <= 1'b0;
    end else if (push) begin
      if (!rda || rd) begin
        rx_data <= shift;
        rda     <= 1'b1;
      end
    end else if (rd) begin
      rda <= 1'b0;
    end
  end
`endif

  // A new error in the same cycle as rd wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push && stop_bad) frame_err <= 1'b1;
      else if (rd)          frame_err <= 1'b0;
      if (drop)             overrun   <= 1'b1;
      else if (rd)          overrun   <= 1'b0;
    end
  end

endmodule
